// File: rtl/add_sub_norm_pkg.sv
// Shared constants and the pipeline payload for the shared mantissa normalizer.
// The payload struct is sized from these constants, so width changes are made here.
package add_sub_norm_pkg;

  localparam int NORM_NUM_REQ    = 4;
  localparam int NORM_SIZE_DATA  = 28;
  localparam int NORM_SIZE_SHIFT = 5;
  localparam int NORM_SIZE_EXP   = 8;
  localparam int NORM_ID_W       = (NORM_NUM_REQ > 1) ? $clog2(NORM_NUM_REQ) : 1;

  typedef struct packed {
    logic [NORM_SIZE_DATA-1:0]  data;
    logic [NORM_SIZE_EXP-1:0]   exp;
    logic [NORM_ID_W-1:0]       id;
    logic [NORM_SIZE_SHIFT-1:0] shift;
    logic                       zero;
    logic                       uflow;
  } norm_stage_t;

  // Round-robin successor of a granted index.
  function automatic logic [NORM_ID_W-1:0] rr_next(input logic [NORM_ID_W-1:0] idx);
    if (int'(idx) == NORM_NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/ADD_SUB_SHF_left.sv
// Logarithmic left barrel shifter: one stage per shift-amount bit.
module ADD_SUB_SHF_left #(
  parameter int SIZE_DATA  = 28,
  parameter int SIZE_SHIFT = 5
) (
  input  logic [SIZE_DATA-1:0]  i_data,
  input  logic [SIZE_SHIFT-1:0] i_shift,
  output logic [SIZE_DATA-1:0]  o_data
);

  logic [SIZE_DATA-1:0] stg [SIZE_SHIFT+1];

  always_comb begin
    stg[0] = i_data;
    for (int s = 0; s < SIZE_SHIFT; s++) begin
      stg[s+1] = i_shift[s] ? (stg[s] << (1 << s)) : stg[s];
    end
    o_data = stg[SIZE_SHIFT];
  end

endmodule

// File: rtl/add_sub_lzc.sv
// Combinational leading-zero counter. The count for an all-zero input is
// not meaningful; callers handle zero mantissas separately.
module add_sub_lzc #(
  parameter int SIZE_DATA  = 28,
  parameter int SIZE_SHIFT = 5
) (
  input  logic [SIZE_DATA-1:0]  i_data,
  output logic [SIZE_SHIFT-1:0] o_lzc
);

  int   cnt;
  logic found;

  always_comb begin
    cnt   = 0;
    found = 1'b0;
    for (int i = SIZE_DATA - 1; i >= 0; i--) begin
      if (!found) begin
        if (i_data[i]) found = 1'b1;
        else           cnt   = cnt + 1;
      end
    end
    o_lzc = SIZE_SHIFT'(cnt);
  end

endmodule

// File: rtl/add_sub_norm_arb.sv
// Round-robin arbiter in front of a two-stage mantissa normalizer
// (stage 1: capture + lzc, stage 2: shift amount/exponent, shifter on the output).
module add_sub_norm_arb
  import add_sub_norm_pkg::*;
#(
  parameter int NUM_REQ    = NORM_NUM_REQ,
  parameter int SIZE_DATA  = NORM_SIZE_DATA,
  parameter int SIZE_SHIFT = NORM_SIZE_SHIFT,
  parameter int SIZE_EXP   = NORM_SIZE_EXP
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ-1:0][SIZE_DATA-1:0]  i_req_data,
  input  logic [NUM_REQ-1:0][SIZE_EXP-1:0]   i_req_exp,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  output logic                               o_res_valid,
  input  logic                               i_res_ready,
  output logic [SIZE_DATA-1:0]               o_res_data,
  output logic [SIZE_EXP-1:0]                o_res_exp,
  output logic [NORM_ID_W-1:0]               o_res_id,
  output logic                               o_res_zero,
  output logic                               o_res_uflow
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; ready never depends on the same-side valid of other inputs
  // except through the arbiter pick, and results are held while not accepted.

  logic [NORM_ID_W-1:0]  rr_ptr;
  logic [NORM_ID_W-1:0]  grant_idx;
  logic                  grant_any;
  logic                  s1_valid;
  logic                  s2_valid;
  logic                  s1_accept;
  logic                  s2_load;
  norm_stage_t           s1_q;
  norm_stage_t           s2_q;
  norm_stage_t           s2_nxt;
  logic [SIZE_SHIFT-1:0] s1_lzc;

  // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
  always_comb begin : arb
    int k;
    k         = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!grant_any && i_req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = NORM_ID_W'(k);
      end
    end
  end

  assign s2_load   = !s2_valid || i_res_ready;
  assign s1_accept = i_rst_n && grant_any && (!s1_valid || s2_load);

  always_comb begin
    o_req_ready = '0;
    if (s1_accept) o_req_ready = NUM_REQ'(1) << grant_idx;
  end

  add_sub_lzc #(
    .SIZE_DATA  (SIZE_DATA),
    .SIZE_SHIFT (SIZE_SHIFT)
  ) u_lzc (
    .i_data (s1_q.data),
    .o_lzc  (s1_lzc)
  );

  // Normalize as far as the exponent allows; stop at exponent 0 (denormal).
  always_comb begin
    s2_nxt       = s1_q;
    s2_nxt.shift = '0;
    s2_nxt.zero  = 1'b0;
    s2_nxt.uflow = 1'b0;
    if (s1_q.data == '0) begin
      s2_nxt.exp  = '0;
      s2_nxt.zero = 1'b1;
    end else if (s1_q.exp == '0) begin
      s2_nxt.exp = '0;
    end else if (int'(s1_q.exp) > int'(s1_lzc)) begin
      s2_nxt.shift = s1_lzc;
      s2_nxt.exp   = SIZE_EXP'(int'(s1_q.exp) - int'(s1_lzc));
    end else begin
      s2_nxt.shift = SIZE_SHIFT'(int'(s1_q.exp) - 1);
      s2_nxt.exp   = '0;
      s2_nxt.uflow = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else begin
      if (s1_accept) begin
        s1_valid <= 1'b1;
        s1_q     <= '{data:  i_req_data[grant_idx],
                      exp:   i_req_exp[grant_idx],
                      id:    grant_idx,
                      shift: '0,
                      zero:  1'b0,
                      uflow: 1'b0};
        rr_ptr   <= rr_next(grant_idx);
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_nxt;
      end
    end
  end

  ADD_SUB_SHF_left #(
    .SIZE_DATA  (SIZE_DATA),
    .SIZE_SHIFT (SIZE_SHIFT)
  ) u_shf (
    .i_data  (s2_q.data),
    .i_shift (s2_q.shift),
    .o_data  (o_res_data)
  );

  assign o_res_valid = s2_valid;
  assign o_res_exp   = s2_q.exp;
  assign o_res_id    = s2_q.id;
  assign o_res_zero  = s2_q.zero;
  assign o_res_uflow = s2_q.uflow;

endmodule
